// File: rtl/crossy_robbers_soc_irq_ctrl_if.sv
// Avalon-MM style slave bus for the SoC interrupt controller.
// Word addresses, active-low write, registered readdata.
interface crossy_robbers_soc_irq_ctrl_if;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [15:0] writedata;
  logic [15:0] readdata;

  modport master (
    output address,
    output chipselect,
    output write_n,
    output writedata,
    input  readdata
  );

  modport slave (
    input  address,
    input  chipselect,
    input  write_n,
    input  writedata,
    output readdata
  );
endinterface

// File: rtl/crossy_robbers_soc_irq_ctrl.sv
// SoC interrupt controller: level/edge capture, pending set, enable mask,
// lowest-index priority, saturating missed-edge counter.
module crossy_robbers_soc_irq_ctrl #(
  parameter int NUM_IRQ = 8,
  parameter int MISS_W  = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [NUM_IRQ-1:0]   irq_in,
  crossy_robbers_soc_irq_ctrl_if.slave bus,
  output logic                 irq_out,
  output logic [3:0]           irq_id
);
  localparam logic [MISS_W-1:0] MISS_MAX = '1;

  logic [NUM_IRQ-1:0] r_irq_q;
  logic [NUM_IRQ-1:0] r_irq_d;
  logic [NUM_IRQ-1:0] r_pend;
  logic [NUM_IRQ-1:0] r_en;
  logic [NUM_IRQ-1:0] r_edge;
  logic [MISS_W-1:0]  r_miss;
  logic               r_irq_out;
  logic [3:0]         r_irq_id;
  logic [15:0]        r_rdata;

  logic               w_wr;
  logic [NUM_IRQ-1:0] w_wdata;
  logic [NUM_IRQ-1:0] w_rise;
  logic [NUM_IRQ-1:0] w_w1c;
  logic [NUM_IRQ-1:0] w_force;
  logic [NUM_IRQ-1:0] w_mode;
  logic [NUM_IRQ-1:0] w_pend_nx;
  logic [NUM_IRQ-1:0] w_act;
  logic [NUM_IRQ-1:0] w_miss_bits;
  logic               w_miss_clr;
  logic               w_miss_inc;
  logic               w_any;
  logic [3:0]         w_id;
  logic [15:0]        w_rdata;

  assign w_wr    = bus.chipselect & ~bus.write_n;
  assign w_wdata = bus.writedata[NUM_IRQ-1:0];
  assign w_rise  = r_irq_q & ~r_irq_d;

  assign w_w1c   = (w_wr && bus.address == 3'd0) ? w_wdata : '0;
  assign w_force = (w_wr && bus.address == 3'd4) ? w_wdata : '0;
  assign w_miss_clr = w_wr && bus.address == 3'd5;

  // Bits changing mode this cycle stay latched once, then take the new mode
  assign w_mode = (w_wr && bus.address == 3'd2) ?
                  (r_edge | w_wdata) : r_edge;

  assign w_pend_nx =
    (w_mode & ((r_pend & ~w_w1c) | w_rise | w_force)) |
    (~w_mode & r_irq_q);

  assign w_miss_bits = r_edge & w_rise & r_pend & ~w_w1c;
  assign w_miss_inc  = (|w_miss_bits) && (r_miss != MISS_MAX);

  assign w_act = r_pend & r_en;
  assign w_any = |w_act;

  always_comb begin
    w_id = 4'd0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (w_act[i]) w_id = 4'(i);
    end
  end

  always_comb begin
    w_rdata = '0;
    case (bus.address)
      3'd0:    w_rdata[NUM_IRQ-1:0] = r_pend;
      3'd1:    w_rdata[NUM_IRQ-1:0] = r_en;
      3'd2:    w_rdata[NUM_IRQ-1:0] = r_edge;
      3'd3:    w_rdata[4:0]         = {r_irq_out, r_irq_id};
      3'd5:    w_rdata[MISS_W-1:0]  = r_miss;
      default: w_rdata              = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_irq_q   <= '0;
      r_irq_d   <= '0;
      r_pend    <= '0;
      r_en      <= '0;
      r_edge    <= '0;
      r_miss    <= '0;
      r_irq_out <= 1'b0;
      r_irq_id  <= 4'd0;
      r_rdata   <= '0;
    end else begin
      r_irq_q   <= irq_in;
      r_irq_d   <= r_irq_q;
      r_pend    <= w_pend_nx;
      r_irq_out <= w_any;
      r_irq_id  <= w_id;
      r_rdata   <= w_rdata;
      if (w_wr && bus.address == 3'd1) r_en   <= w_wdata;
      if (w_wr && bus.address == 3'd2) r_edge <= w_wdata;
      if (w_miss_clr)      r_miss <= '0;
      else if (w_miss_inc) r_miss <= r_miss + 1'b1;
    end
  end

  assign bus.readdata = r_rdata;
  assign irq_out      = r_irq_out;
  assign irq_id       = r_irq_id;
endmodule

// File: tb/tb_crossy_robbers_soc_irq_ctrl.sv
// Scoreboard bench for the interrupt controller; a second instance with
// a 2-bit missed counter shadows the main one to cover saturation.
module tb_crossy_robbers_soc_irq_ctrl;
  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [7:0] irq_in = '0;
  logic       irq_out0, irq_out1;
  logic [3:0] irq_id0, irq_id1;

  int checks = 0;
  int errors = 0;
  logic [15:0] sb[$];
  logic [15:0] e;
  logic [15:0] v0, v1;

  crossy_robbers_soc_irq_ctrl_if b0 ();
  crossy_robbers_soc_irq_ctrl_if b1 ();

  crossy_robbers_soc_irq_ctrl #(.NUM_IRQ(8), .MISS_W(16)) dut0 (
    .clk(clk), .reset_n(reset_n), .irq_in(irq_in),
    .bus(b0.slave), .irq_out(irq_out0), .irq_id(irq_id0)
  );

  crossy_robbers_soc_irq_ctrl #(.NUM_IRQ(8), .MISS_W(2)) dut1 (
    .clk(clk), .reset_n(reset_n), .irq_in(irq_in),
    .bus(b1.slave), .irq_out(irq_out1), .irq_id(irq_id1)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wr(input logic [2:0] a, input logic [15:0] d);
    b0.chipselect = 1'b1; b0.write_n = 1'b0;
    b0.address = a; b0.writedata = d;
    b1.chipselect = 1'b1; b1.write_n = 1'b0;
    b1.address = a; b1.writedata = d;
    @(negedge clk);
    b0.chipselect = 1'b0; b0.write_n = 1'b1;
    b1.chipselect = 1'b0; b1.write_n = 1'b1;
  endtask

  task automatic rd(input logic [2:0] a,
                    output logic [15:0] r0, output logic [15:0] r1);
    b0.address = a;
    b1.address = a;
    @(negedge clk);
    r0 = b0.readdata;
    r1 = b1.readdata;
  endtask

  task automatic test_reset;
    tick(2);
    sb.push_back(16'h0); sb.push_back(16'h0); sb.push_back(16'h0);
    e = sb.pop_front(); checks++;
    if (b0.readdata !== e) begin
      errors++; $display("FAIL rst_rdata got %0h exp %0h", b0.readdata, e);
    end
    e = sb.pop_front(); checks++;
    if ({15'b0, irq_out0} !== e) begin
      errors++; $display("FAIL rst_irq_out got %0h exp %0h", irq_out0, e);
    end
    e = sb.pop_front(); checks++;
    if ({12'b0, irq_id0} !== e) begin
      errors++; $display("FAIL rst_irq_id got %0h exp %0h", irq_id0, e);
    end
    reset_n = 1'b1;
    tick(1);
  endtask

  task automatic test_level;
    wr(3'd1, 16'h0001);
    irq_in[0] = 1'b1;
    sb.push_back(16'h0); sb.push_back(16'h0); sb.push_back(16'h1);
    for (int k = 0; k < 3; k++) begin
      tick(1);
      e = sb.pop_front(); checks++;
      if ({15'b0, irq_out0} !== e) begin
        errors++; $display("FAIL lvl_rise_%0d got %0h exp %0h", k, irq_out0, e);
      end
    end
    sb.push_back(16'h0);
    e = sb.pop_front(); checks++;
    if ({12'b0, irq_id0} !== e) begin
      errors++; $display("FAIL lvl_id got %0h exp %0h", irq_id0, e);
    end
    wr(3'd0, 16'h0001);
    sb.push_back(16'h0001);
    rd(3'd0, v0, v1);
    e = sb.pop_front(); checks++;
    if (v0 !== e) begin
      errors++; $display("FAIL lvl_w1c got %0h exp %0h", v0, e);
    end
    irq_in[0] = 1'b0;
    sb.push_back(16'h1); sb.push_back(16'h1); sb.push_back(16'h0);
    for (int k = 0; k < 3; k++) begin
      tick(1);
      e = sb.pop_front(); checks++;
      if ({15'b0, irq_out0} !== e) begin
        errors++; $display("FAIL lvl_fall_%0d got %0h exp %0h", k, irq_out0, e);
      end
    end
  endtask

  task automatic test_edge;
    wr(3'd2, 16'h0004);
    wr(3'd1, 16'h0004);
    irq_in[2] = 1'b1;
    tick(1);
    irq_in[2] = 1'b0;
    tick(4);
    sb.push_back(16'h0004); sb.push_back(16'h1); sb.push_back(16'h2);
    rd(3'd0, v0, v1);
    e = sb.pop_front(); checks++;
    if (v0 !== e) begin
      errors++; $display("FAIL edge_pend got %0h exp %0h", v0, e);
    end
    e = sb.pop_front(); checks++;
    if ({15'b0, irq_out0} !== e) begin
      errors++; $display("FAIL edge_out got %0h exp %0h", irq_out0, e);
    end
    e = sb.pop_front(); checks++;
    if ({12'b0, irq_id0} !== e) begin
      errors++; $display("FAIL edge_id got %0h exp %0h", irq_id0, e);
    end
    wr(3'd0, 16'h0004);
    sb.push_back(16'h1);
    e = sb.pop_front(); checks++;
    if ({15'b0, irq_out0} !== e) begin
      errors++; $display("FAIL edge_w1c_out0 got %0h exp %0h", irq_out0, e);
    end
    sb.push_back(16'h0); sb.push_back(16'h0);
    rd(3'd0, v0, v1);
    e = sb.pop_front(); checks++;
    if (v0 !== e) begin
      errors++; $display("FAIL edge_w1c_pend got %0h exp %0h", v0, e);
    end
    e = sb.pop_front(); checks++;
    if ({15'b0, irq_out0} !== e) begin
      errors++; $display("FAIL edge_w1c_out1 got %0h exp %0h", irq_out0, e);
    end
  endtask

  task automatic test_priority;
    wr(3'd2, 16'h00FF);
    wr(3'd1, 16'h00FF);
    wr(3'd4, 16'h0090);
    tick(1);
    sb.push_back(16'h4); sb.push_back(16'h0014);
    e = sb.pop_front(); checks++;
    if ({12'b0, irq_id0} !== e) begin
      errors++; $display("FAIL prio_id4 got %0h exp %0h", irq_id0, e);
    end
    rd(3'd3, v0, v1);
    e = sb.pop_front(); checks++;
    if (v0 !== e) begin
      errors++; $display("FAIL prio_status got %0h exp %0h", v0, e);
    end
    wr(3'd0, 16'h0010);
    tick(1);
    sb.push_back(16'h7);
    e = sb.pop_front(); checks++;
    if ({12'b0, irq_id0} !== e) begin
      errors++; $display("FAIL prio_id7 got %0h exp %0h", irq_id0, e);
    end
    wr(3'd1, 16'h0000);
    tick(1);
    sb.push_back(16'h0); sb.push_back(16'h0080);
    e = sb.pop_front(); checks++;
    if ({15'b0, irq_out0} !== e) begin
      errors++; $display("FAIL prio_masked got %0h exp %0h", irq_out0, e);
    end
    rd(3'd0, v0, v1);
    e = sb.pop_front(); checks++;
    if (v0 !== e) begin
      errors++; $display("FAIL prio_pend got %0h exp %0h", v0, e);
    end
  endtask

  task automatic test_set_beats_clear;
    wr(3'd0, 16'h00FF);
    wr(3'd4, 16'h0002);
    irq_in[1] = 1'b1;
    tick(1);
    irq_in[1] = 1'b0;
    wr(3'd0, 16'h0002);
    tick(1);
    sb.push_back(16'h0002); sb.push_back(16'h0); sb.push_back(16'h0);
    rd(3'd0, v0, v1);
    e = sb.pop_front(); checks++;
    if (v0 !== e) begin
      errors++; $display("FAIL sbc_pend got %0h exp %0h", v0, e);
    end
    rd(3'd5, v0, v1);
    e = sb.pop_front(); checks++;
    if (v0 !== e) begin
      errors++; $display("FAIL sbc_missed got %0h exp %0h", v0, e);
    end
    e = sb.pop_front(); checks++;
    if (v1 !== e) begin
      errors++; $display("FAIL sbc_missed_w2 got %0h exp %0h", v1, e);
    end
  endtask

  task automatic pulse3(input int n);
    for (int k = 0; k < n; k++) begin
      irq_in[3] = 1'b1;
      tick(1);
      irq_in[3] = 1'b0;
      tick(2);
    end
  endtask

  task automatic test_missed;
    wr(3'd0, 16'h00FF);
    wr(3'd5, 16'h0000);
    wr(3'd4, 16'h0008);
    pulse3(3);
    sb.push_back(16'd3);
    rd(3'd5, v0, v1);
    e = sb.pop_front(); checks++;
    if (v0 !== e) begin
      errors++; $display("FAIL miss_3 got %0h exp %0h", v0, e);
    end
    pulse3(2);
    sb.push_back(16'd5); sb.push_back(16'd3);
    rd(3'd5, v0, v1);
    e = sb.pop_front(); checks++;
    if (v0 !== e) begin
      errors++; $display("FAIL miss_5 got %0h exp %0h", v0, e);
    end
    e = sb.pop_front(); checks++;
    if (v1 !== e) begin
      errors++; $display("FAIL miss_sat got %0h exp %0h", v1, e);
    end
    wr(3'd5, 16'h1234);
    sb.push_back(16'd0); sb.push_back(16'd0);
    rd(3'd5, v0, v1);
    e = sb.pop_front(); checks++;
    if (v0 !== e) begin
      errors++; $display("FAIL miss_clr got %0h exp %0h", v0, e);
    end
    e = sb.pop_front(); checks++;
    if (v1 !== e) begin
      errors++; $display("FAIL miss_clr_w2 got %0h exp %0h", v1, e);
    end
  endtask

  task automatic test_async_reset;
    wr(3'd1, 16'h00FF);
    wr(3'd4, 16'h00FF);
    tick(1);
    sb.push_back(16'h00FF); sb.push_back(16'h1);
    rd(3'd0, v0, v1);
    e = sb.pop_front(); checks++;
    if (v0 !== e) begin
      errors++; $display("FAIL ar_pre_pend got %0h exp %0h", v0, e);
    end
    e = sb.pop_front(); checks++;
    if ({15'b0, irq_out0} !== e) begin
      errors++; $display("FAIL ar_pre_out got %0h exp %0h", irq_out0, e);
    end
    irq_in[0] = 1'b1;
    #2;
    reset_n = 1'b0;
    #1;
    sb.push_back(16'h0); sb.push_back(16'h0);
    e = sb.pop_front(); checks++;
    if (b0.readdata !== e) begin
      errors++; $display("FAIL ar_rdata got %0h exp %0h", b0.readdata, e);
    end
    e = sb.pop_front(); checks++;
    if ({15'b0, irq_out0} !== e) begin
      errors++; $display("FAIL ar_out got %0h exp %0h", irq_out0, e);
    end
    tick(1);
    reset_n = 1'b1;
    tick(1);
    sb.push_back(16'h0); sb.push_back(16'h1);
    rd(3'd0, v0, v1);
    e = sb.pop_front(); checks++;
    if (v0 !== e) begin
      errors++; $display("FAIL ar_pend_r1 got %0h exp %0h", v0, e);
    end
    rd(3'd0, v0, v1);
    e = sb.pop_front(); checks++;
    if (v0 !== e) begin
      errors++; $display("FAIL ar_pend_r2 got %0h exp %0h", v0, e);
    end
    irq_in[0] = 1'b0;
  endtask

  initial begin
    b0.address = '0; b0.chipselect = 1'b0;
    b0.write_n = 1'b1; b0.writedata = '0;
    b1.address = '0; b1.chipselect = 1'b0;
    b1.write_n = 1'b1; b1.writedata = '0;
    test_reset();
    test_level();
    test_edge();
    test_priority();
    test_set_beats_clear();
    test_missed();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
